// File: rtl/tl_ul_protocol_checker.sv
// tl_ul_protocol_checker: passive TileLink-UL A/D link checker with coded, sticky and counted violation reporting
// Ports: clock/reset_n (async active-low); a_* and d_* observe the link (never driven);
//        err_valid/err_code pulse the lowest violation of the previous cycle; err_sticky ORs all
//        violation bits since reset; err_count counts error cycles (saturating); outstanding = busy sources.
module tl_ul_protocol_checker #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int SRC_W   = 2,
   parameter int SIZE_W  = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 a_valid,
   input  logic                 a_ready,
   input  logic [2:0]           a_opcode,
   input  logic [2:0]           a_param,
   input  logic [SIZE_W-1:0]    a_size,
   input  logic [SRC_W-1:0]     a_source,
   input  logic [ADDR_W-1:0]    a_address,
   input  logic [DATA_W/8-1:0]  a_mask,
   input  logic                 d_valid,
   input  logic                 d_ready,
   input  logic [2:0]           d_opcode,
   input  logic [1:0]           d_param,
   input  logic [SIZE_W-1:0]    d_size,
   input  logic [SRC_W-1:0]     d_source,
   output logic                 err_valid,
   output logic [3:0]           err_code,
   output logic [11:0]          err_sticky,
   output logic [15:0]          err_count,
   output logic [SRC_W:0]       outstanding
);
   localparam int LANES = DATA_W / 8;
   localparam int LB    = $clog2(LANES);
   localparam int NSRC  = 1 << SRC_W;
   localparam int CW    = SRC_W + 1;
   localparam int AGE_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam int AF_W  = 6 + SIZE_W + SRC_W + ADDR_W + LANES;
   localparam int DF_W  = 5 + SIZE_W + SRC_W;
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT);
   localparam logic [LANES-1:0] LANE_ONE = LANES'(1);
   localparam logic [2:0] PUT_FULL = 3'd0, PUT_PARTIAL = 3'd1, GET = 3'd4;
   localparam logic [2:0] ACK = 3'd0, ACK_DATA = 3'd1;

   logic                a_fire, d_fire, a_hold, d_hold, mask_bad, op_bad;
   logic [NSRC-1:0]     busy, busy_nxt, is_get, timed_out, tmo_hit;
   logic [SIZE_W-1:0]   size_q [NSRC];
   logic [AGE_W-1:0]    age [NSRC];
   logic [AF_W-1:0]     a_flds, a_prev;
   logic [DF_W-1:0]     d_flds, d_prev;
   logic [ADDR_W-1:0]   size_mask, lane_off;
   logic [LANES-1:0]    lanes_exp;
   logic [11:0]         viol;
   logic [3:0]          code_nxt;
   logic [CW-1:0]       busy_cnt;

   assign a_fire = a_valid & a_ready;
   assign d_fire = d_valid & d_ready;
   assign a_flds = {a_opcode, a_param, a_size, a_source, a_address, a_mask};
   assign d_flds = {d_opcode, d_param, d_size, d_source};

   // Byte lanes a naturally aligned 2^size transfer covers within the bus word.
   assign size_mask = ~({ADDR_W{1'b1}} << a_size);
   assign lane_off  = a_address & ADDR_W'(LANES - 1) & ~size_mask;
   assign lanes_exp = ((LANE_ONE << (32'd1 << a_size)) - LANE_ONE) << lane_off;
   assign op_bad    = a_opcode != PUT_FULL && a_opcode != PUT_PARTIAL && a_opcode != GET;
   assign mask_bad  = (a_opcode == PUT_PARTIAL) ? |(a_mask & ~lanes_exp)
                    : (a_opcode == PUT_FULL || a_opcode == GET) && a_mask != lanes_exp;

   always_comb
      for (int i = 0; i < NSRC; i++)
         tmo_hit[i] = TIMEOUT != 0 && busy[i] && !timed_out[i] && age[i] == AGE_MAX;

   // D-side checks see the table as it stood before any same-cycle A allocation.
   always_comb begin
      viol     = '0;
      viol[0]  = a_valid & op_bad;
      viol[1]  = a_valid & (a_param != 3'd0);
      viol[2]  = a_valid & (a_size > SIZE_W'(LB));
      viol[3]  = a_valid & |(a_address & size_mask);
      viol[4]  = a_valid & mask_bad;
      viol[5]  = a_hold & (~a_valid | (a_flds != a_prev));
      viol[6]  = a_fire & busy[a_source] & ~(d_fire & d_source == a_source);
      viol[7]  = d_valid & ~busy[d_source];
      viol[8]  = d_valid & ((busy[d_source] & d_opcode != (is_get[d_source] ? ACK_DATA : ACK)) | d_param != 2'd0);
      viol[9]  = d_valid & busy[d_source] & (d_size != size_q[d_source]);
      viol[10] = d_hold & (~d_valid | (d_flds != d_prev));
      viol[11] = |tmo_hit;
   end

   always_comb begin
      code_nxt = err_code;
      for (int i = 11; i >= 0; i--)
         if (viol[i]) code_nxt = 4'(i);
   end

   // D retires first so a same-cycle A on the same source re-allocates it.
   always_comb begin
      busy_nxt = busy;
      if (d_fire) busy_nxt[d_source] = 1'b0;
      if (a_fire) busy_nxt[a_source] = 1'b1;
   end

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < NSRC; i++)
         busy_cnt = busy_cnt + CW'(busy_nxt[i]);
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         busy      <= '0;
         is_get    <= '0;
         timed_out <= '0;
         for (int i = 0; i < NSRC; i++) begin
            size_q[i] <= '0;
            age[i]    <= '0;
         end
      end else begin
         busy <= busy_nxt;
         for (int i = 0; i < NSRC; i++)
            if (a_fire && a_source == SRC_W'(i)) begin
               is_get[i]    <= a_opcode == GET;
               size_q[i]    <= a_size;
               age[i]       <= '0;
               timed_out[i] <= 1'b0;
            end else if (busy[i]) begin
               if (age[i] != AGE_MAX) age[i] <= age[i] + AGE_W'(1);
               if (tmo_hit[i]) timed_out[i] <= 1'b1;
            end
      end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         err_valid   <= 1'b0;
         err_code    <= '0;
         err_sticky  <= '0;
         err_count   <= '0;
         outstanding <= '0;
         a_hold      <= 1'b0;
         d_hold      <= 1'b0;
         a_prev      <= '0;
         d_prev      <= '0;
      end else begin
         err_valid   <= |viol;
         err_code    <= code_nxt;
         err_sticky  <= err_sticky | viol;
         if (|viol && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         outstanding <= busy_cnt;
         a_hold      <= a_valid & ~a_ready;
         d_hold      <= d_valid & ~d_ready;
         a_prev      <= a_flds;
         d_prev      <= d_flds;
      end
endmodule

// File: tb/tb_tl_ul_protocol_checker.sv
// tb_tl_ul_protocol_checker: directed and randomized scoreboard bench for tl_ul_protocol_checker
module tb_tl_ul_protocol_checker;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int SRC_W   = 2;
   localparam int SIZE_W  = 3;
   localparam int TIMEOUT = 8;
   localparam int LANES   = DATA_W / 8;
   localparam int LB      = $clog2(LANES);
   localparam int NSRC    = 1 << SRC_W;
   localparam int AF_W    = 6 + SIZE_W + SRC_W + ADDR_W + LANES;
   localparam int DF_W    = 5 + SIZE_W + SRC_W;

   typedef struct {
      longint due;
      bit     v;
      int     code;
      int     sticky;
      int     count;
      int     outst;
   } exp_t;

   logic               clock = 1'b0, reset_n = 1'b1;
   logic               a_valid = 1'b0, a_ready = 1'b0;
   logic [2:0]         a_opcode = '0, a_param = '0;
   logic [SIZE_W-1:0]  a_size = '0;
   logic [SRC_W-1:0]   a_source = '0;
   logic [ADDR_W-1:0]  a_address = '0;
   logic [LANES-1:0]   a_mask = '0;
   logic               d_valid = 1'b0, d_ready = 1'b0;
   logic [2:0]         d_opcode = '0;
   logic [1:0]         d_param = '0;
   logic [SIZE_W-1:0]  d_size = '0;
   logic [SRC_W-1:0]   d_source = '0;
   logic               err_valid;
   logic [3:0]         err_code;
   logic [11:0]        err_sticky;
   logic [15:0]        err_count;
   logic [SRC_W:0]     outstanding;

   exp_t              q[$];
   longint            cyc = 0;
   int                n_chk = 0, n_fail = 0;
   bit                m_busy[NSRC], m_get[NSRC], m_rep[NSRC];
   int                m_size[NSRC];
   longint            m_fire[NSRC];
   bit                a_pend, d_pend;
   logic [AF_W-1:0]   a_snap;
   logic [DF_W-1:0]   d_snap;
   int                m_sticky, m_count, m_code;

   tl_ul_protocol_checker #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
      .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
      .d_size(d_size), .d_source(d_source),
      .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
      .err_count(err_count), .outstanding(outstanding)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(string name, longint act, longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare every output against the scoreboard entry due this cycle.
   always @(negedge clock)
      while (q.size() > 0 && q[0].due <= cyc) begin : mon
         exp_t e;
         e = q.pop_front();
         chk("err_valid", err_valid, e.v);
         chk("err_code", err_code, e.code);
         chk("err_sticky", err_sticky, e.sticky);
         chk("err_count", err_count, e.count);
         chk("outstanding", outstanding, e.outst);
      end

   function automatic logic [LANES-1:0] lanes_for(input logic [ADDR_W-1:0] addr, input int size);
      int bytes = 1 << size;
      int off = (int'(addr % LANES) / bytes) * bytes;
      for (int i = 0; i < LANES; i++) lanes_for[i] = i >= off && i < off + bytes;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < NSRC; s++) begin
         m_busy[s] = 0;
         m_rep[s] = 0;
      end
      a_pend = 0;
      d_pend = 0;
      m_sticky = 0;
      m_count = 0;
      m_code = 0;
   endtask

   // Evaluates this cycle's inputs by the protocol rules and queues next cycle's outputs.
   task automatic model_step();
      bit [11:0] v = '0;
      bit af = a_valid && a_ready;
      bit df = d_valid && d_ready;
      int bytes, n;
      logic [LANES-1:0] want;
      if (a_valid) begin
         v[0] = !(a_opcode == 0 || a_opcode == 1 || a_opcode == 4);
         v[1] = a_param != 0;
         v[2] = int'(a_size) > LB;
         bytes = 1 << a_size;
         v[3] = (a_address % bytes) != 0;
         want = lanes_for(a_address, int'(a_size));
         if (a_opcode == 1) v[4] = (a_mask & ~want) != 0;
         else if (a_opcode == 0 || a_opcode == 4) v[4] = a_mask != want;
      end
      v[5] = a_pend && (!a_valid || {a_opcode, a_param, a_size, a_source, a_address, a_mask} != a_snap);
      v[6] = af && m_busy[a_source] && !(df && d_source == a_source);
      if (d_valid) begin
         if (!m_busy[d_source]) v[7] = 1;
         else begin
            if (d_opcode != (m_get[d_source] ? 3'd1 : 3'd0)) v[8] = 1;
            if (int'(d_size) != m_size[d_source]) v[9] = 1;
         end
         if (d_param != 0) v[8] = 1;
      end
      v[10] = d_pend && (!d_valid || {d_opcode, d_param, d_size, d_source} != d_snap);
      for (int s = 0; s < NSRC; s++)
         if (m_busy[s] && !m_rep[s] && cyc - m_fire[s] - 1 >= TIMEOUT) begin
            v[11] = 1;
            m_rep[s] = 1;
         end
      a_pend = a_valid && !a_ready;
      d_pend = d_valid && !d_ready;
      a_snap = {a_opcode, a_param, a_size, a_source, a_address, a_mask};
      d_snap = {d_opcode, d_param, d_size, d_source};
      if (df) m_busy[d_source] = 0;
      if (af) begin
         m_busy[a_source] = 1;
         m_get[a_source] = a_opcode == 4;
         m_size[a_source] = int'(a_size);
         m_fire[a_source] = cyc;
         m_rep[a_source] = 0;
      end
      n = 0;
      for (int s = 0; s < NSRC; s++) n += int'(m_busy[s]);
      if (v != 0) begin
         if (m_count < 'hFFFF) m_count++;
         m_sticky |= int'(v);
         for (int i = 0; i < 12; i++)
            if (v[i]) begin
               m_code = i;
               break;
            end
      end
      q.push_back('{cyc + 1, v != 0, m_code, m_sticky, m_count, n});
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(int n);
      a_valid = 0;
      d_valid = 0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      q.delete();
      q.push_back('{cyc, 0, 0, 0, 0, 0});
      model_clear();
      @(posedge clock);
      #1;
      q.push_back('{cyc, 0, 0, 0, 0, 0});
      reset_n = 1'b1;
   endtask

   task automatic set_a(bit v, bit rdy, int op, int src, int size, logic [ADDR_W-1:0] addr, int mask);
      a_valid = v;
      a_ready = rdy;
      a_opcode = 3'(op);
      a_param = '0;
      a_size = SIZE_W'(size);
      a_source = SRC_W'(src);
      a_address = addr;
      a_mask = LANES'(mask);
   endtask

   task automatic set_d(bit v, bit rdy, int op, int src, int size);
      d_valid = v;
      d_ready = rdy;
      d_opcode = 3'(op);
      d_param = '0;
      d_size = SIZE_W'(size);
      d_source = SRC_W'(src);
   endtask

   task automatic rand_inputs();
      int s;
      int bsy[$];
      if (a_pend && $urandom_range(9) != 0) a_valid = 1'b1;
      else begin
         a_valid = $urandom_range(2) != 0;
         s = $urandom_range(NSRC - 1);
         for (int t = 0; t < 4 && m_busy[s]; t++) s = $urandom_range(NSRC - 1);
         a_source = SRC_W'(s);
         case ($urandom_range(2))
            0: a_opcode = 3'd0;
            1: a_opcode = 3'd1;
            default: a_opcode = 3'd4;
         endcase
         a_param = '0;
         a_size = SIZE_W'($urandom_range(LB));
         a_address = $urandom & ~ADDR_W'((1 << a_size) - 1);
         a_mask = lanes_for(a_address, int'(a_size));
         if (a_opcode == 3'd1) a_mask &= LANES'($urandom);
         if ($urandom_range(11) == 0)
            case ($urandom_range(4))
               0: a_opcode = 3'($urandom);
               1: a_param = 3'($urandom);
               2: a_size = SIZE_W'($urandom);
               3: a_address[0] = ~a_address[0];
               default: a_mask = LANES'($urandom);
            endcase
      end
      a_ready = $urandom_range(1) != 0;
      if (d_pend && $urandom_range(9) != 0) d_valid = 1'b1;
      else begin
         for (int i = 0; i < NSRC; i++) if (m_busy[i]) bsy.push_back(i);
         if (bsy.size() > 0 && $urandom_range(2) != 0) begin
            s = bsy[$urandom_range(bsy.size() - 1)];
            set_d(1, 0, m_get[s] ? 1 : 0, s, m_size[s]);
            if ($urandom_range(11) == 0)
               case ($urandom_range(2))
                  0: d_opcode = 3'($urandom);
                  1: d_param = 2'($urandom);
                  default: d_size = SIZE_W'($urandom);
               endcase
         end else begin
            set_d($urandom_range(15) == 0, 0, $urandom_range(7), $urandom_range(NSRC - 1), $urandom_range(7));
         end
      end
      d_ready = $urandom_range(3) != 0;
   endtask

   initial begin
      @(posedge clock);
      #1;
      do_reset();
      // clean Get / AccessAckData
      set_a(1, 1, 4, 1, 2, 'h100, 'hF); tick();
      idle(2);
      set_d(1, 1, 1, 1, 2); tick();
      idle(2);
      // misaligned PutFull with bad mask
      set_a(1, 1, 0, 0, 2, 'h102, 'h3); tick();
      idle(1);
      set_d(1, 1, 0, 0, 2); tick();
      idle(1);
      // A field changes while stalled
      set_a(1, 0, 4, 0, 2, 'h40, 'hF); tick();
      a_address = 'h44; a_ready = 1; tick();
      idle(1);
      set_d(1, 1, 1, 0, 2); tick();
      idle(1);
      // source reuse, then reuse covered by same-cycle retire
      set_a(1, 1, 4, 2, 2, 'h200, 'hF); tick();
      idle(1);
      set_a(1, 1, 4, 2, 2, 'h200, 'hF); tick();
      set_d(1, 1, 1, 2, 2); tick();
      a_valid = 0; tick();
      idle(1);
      // unexpected D, wrong opcode, wrong size
      set_d(1, 1, 0, 3, 2); tick();
      d_valid = 0;
      set_a(1, 1, 0, 0, 2, 'h0, 'hF); tick();
      a_valid = 0; set_d(1, 1, 1, 0, 2); tick();
      d_valid = 0; set_a(1, 1, 0, 0, 2, 'h0, 'hF); tick();
      a_valid = 0; set_d(1, 1, 0, 0, 1); tick();
      idle(1);
      // timeout
      set_a(1, 1, 4, 0, 2, 'h80, 'hF); tick();
      idle(14);
      set_d(1, 1, 1, 0, 2); tick();
      idle(1);
      // reset mid-transaction with a stalled A pending, then stale response
      set_a(1, 1, 4, 0, 2, 'h80, 'hF); tick();
      set_a(1, 0, 4, 1, 2, 'h84, 'hF); tick();
      do_reset();
      idle(1);
      set_d(1, 1, 1, 0, 2); tick();
      idle(2);
      // randomized traffic with occasional resets
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(999) == 0) do_reset();
         rand_inputs();
         tick();
      end
      idle(3);
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clock);
      #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
